multicycle_control: RTL and testbench

//  - Moore FSM that sequences a shared-memory multi-cycle MIPS datapath (IR, A/B, ALUOut, MDR, PC regs).
//  - Takes the opcode from the IR and drives every datapath strobe and mux select, one state per cycle.
//  - Holds in memory states until memory answers, so a slow unified memory needs no datapath change.
//  - Sits beside alu_control: it drives ALUOp, and alu_control refines it with funct.

---
 rtl/multicycle_pkg.sv | 71 +++++++
 rtl/multicycle_control_if.sv | 38 +++
 rtl/multicycle_control_output_decode.sv | 96 +++++++++
 rtl/multicycle_control.sv | 103 ++++++++++
 tb/tb_multicycle_control.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_pkg.sv
// Shared opcodes, state encoding and control codes for the multi-cycle MIPS controller.
// alu_control imports the ALUOp codes from here so both sides agree on their meaning.
package multicycle_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_IMM_EX = 4'd9,
    S_IMM_WB = 4'd10,
`ifdef ILLEGAL_TRAP_EN
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
`else
    S_JUMP   = 4'd11
`endif
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J)    || (op == OP_BEQ)  || (op == OP_BNE) ||
           (op == OP_ADDI)  || (op == OP_ANDI) || (op == OP_LW)   || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode/mem_ready in, every strobe and select out.
interface multicycle_control_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         opcode;
  logic               mem_ready;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               PCWriteCondNe;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MemtoReg;
  logic               RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic [1:0]         PCSource;
  logic               instr_done;
  logic               illegal;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done, illegal, state_dbg
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done, illegal, state_dbg
  );
endinterface

// File: rtl/multicycle_control_output_decode.sv
// Combinational Moore decode: current state (+ latched opcode, memory ready) -> datapath strobes.
module mc_output_decode
  import multicycle_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op_q,
  input  logic       ready,
  input  logic       kill,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = ready;
        ctrl.pc_write  = ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        // Write strobe stays up through the wait; the instruction retires on the ready cycle.
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a        = 1'b1;
        ctrl.alu_src_b        = SRCB_REG;
        ctrl.alu_op           = ALUOP_SUB;
        ctrl.pc_source        = PCSRC_ALUOUT;
        ctrl.pc_write_cond    = (op_q == OP_BEQ);
        ctrl.pc_write_cond_ne = (op_q == OP_BNE);
        ctrl.instr_done       = 1'b1;
      end
      S_IMM_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = (op_q == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
      end
      S_IMM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase

    // Reset cycle must never touch PC, IR, memory or the register file.
    if (kill) begin
      ctrl.pc_write         = 1'b0;
      ctrl.pc_write_cond    = 1'b0;
      ctrl.pc_write_cond_ne = 1'b0;
      ctrl.mem_read         = 1'b0;
      ctrl.mem_write        = 1'b0;
      ctrl.ir_write         = 1'b0;
      ctrl.reg_write        = 1'b0;
      ctrl.instr_done       = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the shared-memory multi-cycle MIPS datapath.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes in TRAP with a sticky illegal flag.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int STATE_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_control_if.master  bus
);

  state_t     state_reg;
  logic [5:0] op_q;
  logic       ready;
  ctrl_t      ctrl;

  assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
      op_q      <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_FETCH:  if (ready) state_reg <= S_DECODE;
        S_DECODE: begin
          op_q <= bus.opcode;
          if (!is_known_op(bus.opcode)) begin
`ifdef ILLEGAL_TRAP_EN
            state_reg   <= S_TRAP;
            illegal_reg <= 1'b1;
`else
            state_reg <= S_FETCH;
`endif
          end else begin
            case (bus.opcode)
              OP_LW, OP_SW:     state_reg <= S_MEMADR;
              OP_RTYPE:         state_reg <= S_EXEC;
              OP_BEQ, OP_BNE:   state_reg <= S_BRANCH;
              OP_ADDI, OP_ANDI: state_reg <= S_IMM_EX;
              default:          state_reg <= S_JUMP;
            endcase
          end
        end
        S_MEMADR: state_reg <= (op_q == OP_LW) ? S_MEMRD :
                               (op_q == OP_SW) ? S_MEMWR : S_FETCH;
        S_MEMRD:  if (ready) state_reg <= S_MEMWB;
        S_MEMWB:  state_reg <= S_FETCH;
        S_MEMWR:  if (ready) state_reg <= S_FETCH;
        S_EXEC:   state_reg <= S_RWB;
        S_RWB:    state_reg <= S_FETCH;
        S_BRANCH: state_reg <= S_FETCH;
        S_IMM_EX: state_reg <= S_IMM_WB;
        S_IMM_WB: state_reg <= S_FETCH;
        S_JUMP:   state_reg <= S_FETCH;
`ifdef ILLEGAL_TRAP_EN
        S_TRAP:   state_reg <= S_TRAP;
`endif
        default:  state_reg <= S_FETCH;
      endcase
    end
  end

  mc_output_decode u_decode (
    .state (state_reg),
    .op_q  (op_q),
    .ready (ready),
    .kill  (rst),
    .ctrl  (ctrl)
  );

  assign bus.PCWrite       = ctrl.pc_write;
  assign bus.PCWriteCond   = ctrl.pc_write_cond;
  assign bus.PCWriteCondNe = ctrl.pc_write_cond_ne;
  assign bus.IorD          = ctrl.i_or_d;
  assign bus.MemRead       = ctrl.mem_read;
  assign bus.MemWrite      = ctrl.mem_write;
  assign bus.IRWrite       = ctrl.ir_write;
  assign bus.MemtoReg      = ctrl.mem_to_reg;
  assign bus.RegDst        = ctrl.reg_dst;
  assign bus.RegWrite      = ctrl.reg_write;
  assign bus.ALUSrcA       = ctrl.alu_src_a;
  assign bus.ALUSrcB       = ctrl.alu_src_b;
  assign bus.ALUOp         = ctrl.alu_op;
  assign bus.PCSource      = ctrl.pc_source;
  assign bus.instr_done    = ctrl.instr_done;
  assign bus.state_dbg     = STATE_W'(state_reg);
`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal = illegal_reg;
`else
  assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control: one handshaking DUT, one single-cycle-memory DUT.
module tb_multicycle_control;
  import multicycle_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_if #(.STATE_W(4)) bus1 ();
  multicycle_control_if #(.STATE_W(4)) bus0 ();

  multicycle_control #(.MEM_HANDSHAKE(1'b1), .STATE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  multicycle_control #(.MEM_HANDSHAKE(1'b0), .STATE_W(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  // {PCWrite,PCWriteCond,PCWriteCondNe}_{IorD,MemRead,MemWrite,IRWrite}_
  // {MemtoReg,RegDst,RegWrite,ALUSrcA}_ALUSrcB_ALUOp_PCSource_{instr_done,illegal}
  localparam logic [18:0] O_FETCH   = 19'b100_0101_0000_01_00_00_00;
  localparam logic [18:0] O_FETCH_W = 19'b000_0100_0000_01_00_00_00;
  localparam logic [18:0] O_FETCH_K = 19'b000_0000_0000_01_00_00_00;
  localparam logic [18:0] O_DEC     = 19'b000_0000_0000_11_00_00_00;
  localparam logic [18:0] O_MADR    = 19'b000_0000_0001_10_00_00_00;
  localparam logic [18:0] O_MRD     = 19'b000_1100_0000_00_00_00_00;
  localparam logic [18:0] O_MWB     = 19'b000_0000_1010_00_00_00_10;
  localparam logic [18:0] O_MWB_K   = 19'b000_0000_1000_00_00_00_00;
  localparam logic [18:0] O_MWR_W   = 19'b000_1010_0000_00_00_00_00;
  localparam logic [18:0] O_MWR     = 19'b000_1010_0000_00_00_00_10;
  localparam logic [18:0] O_EXEC    = 19'b000_0000_0001_00_10_00_00;
  localparam logic [18:0] O_RWB     = 19'b000_0000_0110_00_00_00_10;
  localparam logic [18:0] O_BEQ     = 19'b010_0000_0001_00_01_01_10;
  localparam logic [18:0] O_BNE     = 19'b001_0000_0001_00_01_01_10;
  localparam logic [18:0] O_IADD    = 19'b000_0000_0001_10_00_00_00;
  localparam logic [18:0] O_IAND    = 19'b000_0000_0001_10_11_00_00;
  localparam logic [18:0] O_IWB     = 19'b000_0000_0010_00_00_00_10;
  localparam logic [18:0] O_JMP     = 19'b100_0000_0000_00_00_10_10;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [18:0] O_TRAP    = 19'b000_0000_0000_00_00_00_01;
`endif

  logic [18:0] obs1, obs0;
  assign obs1 = {bus1.PCWrite, bus1.PCWriteCond, bus1.PCWriteCondNe, bus1.IorD, bus1.MemRead,
                 bus1.MemWrite, bus1.IRWrite, bus1.MemtoReg, bus1.RegDst, bus1.RegWrite,
                 bus1.ALUSrcA, bus1.ALUSrcB, bus1.ALUOp, bus1.PCSource, bus1.instr_done, bus1.illegal};
  assign obs0 = {bus0.PCWrite, bus0.PCWriteCond, bus0.PCWriteCondNe, bus0.IorD, bus0.MemRead,
                 bus0.MemWrite, bus0.IRWrite, bus0.MemtoReg, bus0.RegDst, bus0.RegWrite,
                 bus0.ALUSrcA, bus0.ALUSrcB, bus0.ALUOp, bus0.PCSource, bus0.instr_done, bus0.illegal};

  typedef struct {
    bit          start;
    bit          chk0;
    string       name;
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    state_t      st;
    logic [18:0] o;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void add(input bit start, input bit chk0, input string name, input logic r,
                              input logic [5:0] op, input logic mr, input state_t st,
                              input logic [18:0] o);
    vec_t v;
    v.start = start; v.chk0 = chk0; v.name = name; v.rst = r;
    v.op = op; v.mr = mr; v.st = st; v.o = o;
    vecs.push_back(v);
  endfunction

  function automatic void chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("[TB] %s ok (%0d)", name, act);
    end
  endfunction

  initial begin
    int done1, done0, rw_cnt, mr_cnt;

    // lw on both DUTs, memory always ready
    add(1, 1, "lw_fetch",   0, OP_LW, 1, S_FETCH,  O_FETCH);
    add(0, 1, "lw_decode",  0, OP_LW, 1, S_DECODE, O_DEC);
    add(0, 1, "lw_memadr",  0, OP_LW, 1, S_MEMADR, O_MADR);
    add(0, 1, "lw_memrd",   0, OP_LW, 1, S_MEMRD,  O_MRD);
    add(0, 1, "lw_memwb",   0, OP_LW, 1, S_MEMWB,  O_MWB);
    add(0, 1, "lw_next",    0, OP_LW, 1, S_FETCH,  O_FETCH);
    // sw with a fetch stall and three write-wait cycles
    add(1, 0, "sw_fetch_w", 0, OP_SW, 0, S_FETCH,  O_FETCH_W);
    add(0, 0, "sw_fetch",   0, OP_SW, 1, S_FETCH,  O_FETCH);
    add(0, 0, "sw_decode",  0, OP_SW, 0, S_DECODE, O_DEC);
    add(0, 0, "sw_memadr",  0, OP_SW, 0, S_MEMADR, O_MADR);
    add(0, 0, "sw_wait1",   0, OP_SW, 0, S_MEMWR,  O_MWR_W);
    add(0, 0, "sw_wait2",   0, OP_SW, 0, S_MEMWR,  O_MWR_W);
    add(0, 0, "sw_wait3",   0, OP_SW, 0, S_MEMWR,  O_MWR_W);
    add(0, 0, "sw_ready",   0, OP_SW, 1, S_MEMWR,  O_MWR);
    add(0, 0, "sw_next",    0, OP_SW, 1, S_FETCH,  O_FETCH);
    // beq then bne; opcode is changed during BRANCH so the latched copy must be used
    add(1, 1, "beq_fetch",  0, OP_BEQ, 1, S_FETCH,  O_FETCH);
    add(0, 1, "beq_decode", 0, OP_BEQ, 1, S_DECODE, O_DEC);
    add(0, 1, "beq_branch", 0, OP_BNE, 1, S_BRANCH, O_BEQ);
    add(0, 1, "bne_fetch",  0, OP_BNE, 1, S_FETCH,  O_FETCH);
    add(0, 1, "bne_decode", 0, OP_BNE, 1, S_DECODE, O_DEC);
    add(0, 1, "bne_branch", 0, OP_BEQ, 1, S_BRANCH, O_BNE);
    add(0, 1, "br_next",    0, OP_BEQ, 1, S_FETCH,  O_FETCH);
    // andi then addi
    add(1, 1, "andi_fetch", 0, OP_ANDI, 1, S_FETCH,  O_FETCH);
    add(0, 1, "andi_dec",   0, OP_ANDI, 1, S_DECODE, O_DEC);
    add(0, 1, "andi_ex",    0, OP_ADDI, 1, S_IMM_EX, O_IAND);
    add(0, 1, "andi_wb",    0, OP_ADDI, 1, S_IMM_WB, O_IWB);
    add(0, 1, "addi_fetch", 0, OP_ADDI, 1, S_FETCH,  O_FETCH);
    add(0, 1, "addi_dec",   0, OP_ADDI, 1, S_DECODE, O_DEC);
    add(0, 1, "addi_ex",    0, OP_ANDI, 1, S_IMM_EX, O_IADD);
    add(0, 1, "addi_wb",    0, OP_ANDI, 1, S_IMM_WB, O_IWB);
    add(0, 1, "imm_next",   0, OP_ANDI, 1, S_FETCH,  O_FETCH);
    // j and R-type
    add(1, 1, "j_fetch",    0, OP_J, 1, S_FETCH,  O_FETCH);
    add(0, 1, "j_decode",   0, OP_J, 1, S_DECODE, O_DEC);
    add(0, 1, "j_jump",     0, OP_J, 1, S_JUMP,   O_JMP);
    add(0, 1, "r_fetch",    0, OP_RTYPE, 1, S_FETCH,  O_FETCH);
    add(0, 1, "r_decode",   0, OP_RTYPE, 1, S_DECODE, O_DEC);
    add(0, 1, "r_exec",     0, OP_RTYPE, 1, S_EXEC,   O_EXEC);
    add(0, 1, "r_rwb",      0, OP_RTYPE, 1, S_RWB,    O_RWB);
    add(0, 1, "r_next",     0, OP_RTYPE, 1, S_FETCH,  O_FETCH);
    // reset mid-instruction
    add(1, 1, "rr_fetch",   0, OP_RTYPE, 1, S_FETCH,  O_FETCH);
    add(0, 1, "rr_decode",  0, OP_RTYPE, 1, S_DECODE, O_DEC);
    add(0, 1, "rr_exec_rst",1, OP_RTYPE, 1, S_EXEC,   O_EXEC);
    add(0, 1, "rr_after",   0, OP_RTYPE, 1, S_FETCH,  O_FETCH);
    add(0, 1, "lr_decode",  0, OP_LW, 1, S_DECODE, O_DEC);
    add(0, 1, "lr_memadr",  0, OP_LW, 1, S_MEMADR, O_MADR);
    add(0, 1, "lr_memrd",   0, OP_LW, 1, S_MEMRD,  O_MRD);
    add(0, 1, "lr_wb_rst",  1, OP_LW, 1, S_MEMWB,  O_MWB_K);
    add(0, 1, "lr_after",   0, OP_LW, 1, S_FETCH,  O_FETCH);
    // unknown opcode
    add(1, 1, "ill_fetch",  0, 6'h3F, 1, S_FETCH,  O_FETCH);
    add(0, 1, "ill_decode", 0, 6'h3F, 1, S_DECODE, O_DEC);
`ifdef ILLEGAL_TRAP_EN
    for (int k = 0; k < 10; k++) add(0, 1, $sformatf("ill_trap%0d", k), 0, 6'h3F, 1, S_TRAP, O_TRAP);
    add(0, 1, "ill_trap_rst", 1, 6'h3F, 1, S_TRAP,  O_TRAP);
    add(0, 1, "ill_cleared",  0, 6'h3F, 1, S_FETCH, O_FETCH);
`else
    add(0, 1, "ill_nop",    0, 6'h3F, 1, S_FETCH,  O_FETCH);
    add(0, 1, "ill_nop2",   0, 6'h3F, 1, S_DECODE, O_DEC);
`endif

    rst = 1'b1;
    bus1.opcode = '0; bus1.mem_ready = 1'b1;
    bus0.opcode = '0; bus0.mem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_state", int'(bus1.state_dbg), int'(S_FETCH));
    chk("reset_outputs", int'(obs1), int'(O_FETCH_K));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].start) begin
        rst = 1'b1;
        @(negedge clk);
      end
      rst = vecs[i].rst;
      bus1.opcode = vecs[i].op; bus0.opcode = vecs[i].op;
      bus1.mem_ready = vecs[i].mr;
      #1;
      n_tests++;
      if (bus1.state_dbg !== 4'(vecs[i].st) || obs1 !== vecs[i].o) begin
        n_fail++;
        $display("[TB] FAIL %s: state=%0d out=%b, expected state=%0d out=%b",
                 vecs[i].name, bus1.state_dbg, obs1, vecs[i].st, vecs[i].o);
      end else begin
        $display("[TB] %s ok state=%0d out=%b", vecs[i].name, bus1.state_dbg, obs1);
      end
      if (vecs[i].chk0) begin
        n_tests++;
        if (bus0.state_dbg !== 4'(vecs[i].st) || obs0 !== vecs[i].o) begin
          n_fail++;
          $display("[TB] FAIL %s_nohs: state=%0d out=%b, expected state=%0d out=%b",
                   vecs[i].name, bus0.state_dbg, obs0, vecs[i].st, vecs[i].o);
        end
      end
      @(negedge clk);
    end

    // lw with stalls: 2 wait cycles in FETCH, 2 in MEMRD; the no-handshake DUT ignores them.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    done1 = -1; done0 = -1; rw_cnt = 0; mr_cnt = 0;
    for (int c = 0; c < 40 && done1 < 0; c++) begin
      bus1.opcode = OP_LW; bus0.opcode = OP_LW;
      bus1.mem_ready = !(c == 0 || c == 1 || c == 5 || c == 6);
      #1;
      if (bus1.RegWrite) rw_cnt++;
      if (bus1.MemRead)  mr_cnt++;
      if (bus1.instr_done && done1 < 0) done1 = c;
      if (bus0.instr_done && done0 < 0) done0 = c;
      @(negedge clk);
    end
    chk("lw_stall_done_cycle", done1, 8);
    chk("lw_nohs_done_cycle", done0, 4);
    chk("lw_stall_regwrite_cycles", rw_cnt, 1);
    chk("lw_stall_memread_cycles", mr_cnt, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
